// File: rtl/btn_conditioner_pkg.sv
// Board-wide defaults for button conditioning so every button instance agrees.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Defaults are derived from the board clock: 20 ms debounce, 2 s long press.
package btn_conditioner_pkg;

  localparam int unsigned BOARD_CLK_HZ = 1_000_000;

  // 20 ms of stable input before a press or release is accepted.
  localparam int unsigned DEB_CYCLES_DEF = BOARD_CLK_HZ / 50;

  // 2 s of holding after the accepted press before the long-press event.
  localparam int unsigned LONG_CYCLES_DEF = BOARD_CLK_HZ * 2;

  // Counter width; 2^24 comfortably exceeds LONG_CYCLES_DEF.
  localparam int unsigned CNT_W_DEF = 24;

endpackage

// File: rtl/btn_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin, reset to 0.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a raw push-button into a clean level plus press/release/long one-cycle events.
// Latency: press/release pulse DEB_CYCLES+2 cycles after the raw edge; long LONG_CYCLES after press.
// Backpressure: none; events are single-cycle pulses that the consumer must sample.
//
// Ports: clk, rst_n (async active-low), btn_raw (async pin, active-high),
//        btn_level (debounced level), btn_press / btn_release / btn_long (1-cycle pulses).
// Parameter constraints: DEB_CYCLES >= 1, LONG_CYCLES > DEB_CYCLES, 2^CNT_W > LONG_CYCLES.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // The sample that moves IDLE->PRESS_WAIT (or HELD->RELEASE_WAIT) is the first
  // stable sample, so the wait state accepts after DEB_CYCLES-1 further samples,
  // i.e. when deb_cnt has reached DEB_CYCLES-2.
  localparam bit              DEB_ONE   = (DEB_CYCLES == 1);
  localparam int unsigned     DEB_LAST_I = (DEB_CYCLES >= 2) ? (DEB_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_LAST_I);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 1);

  logic             btn_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             long_flag, flag_nxt;
  logic             press_nxt, release_nxt, long_nxt, level_nxt;
  logic             clr_hold, counting;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      long_flag   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_nxt;
      long_flag   <= flag_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_long    <= long_nxt;
    end
  end

  // Debounce state machine
  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    clr_hold    = 1'b0;

    case (state)
      IDLE: begin
        if (btn_sync) begin
          deb_nxt = '0;
          if (DEB_ONE) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
            clr_hold  = 1'b1;
          end else begin
            state_nxt = PRESS_WAIT;
          end
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          deb_nxt   = '0;
          press_nxt = 1'b1;
          clr_hold  = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end

      HELD: begin
        if (!btn_sync) begin
          deb_nxt = '0;
          if (DEB_ONE) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE_WAIT;
          end
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync) begin
          // Release bounce: back to HELD without touching hold_cnt.
          state_nxt = HELD;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          deb_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        deb_nxt   = '0;
      end
    endcase

    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
  end

  // Hold counter and long-press event. Counting uses the current state, so the
  // cycle that leaves RELEASE_WAIT still counts and long/release may coincide.
  always_comb begin
    counting = (state == HELD) || (state == RELEASE_WAIT);
    hold_nxt = hold_cnt;
    flag_nxt = long_flag;
    long_nxt = 1'b0;

    if (counting) begin
      if (hold_cnt != LONG_MAX) begin
        hold_nxt = hold_cnt + 1'b1;
      end
      if ((hold_cnt == LONG_PRE) && !long_flag) begin
        long_nxt = 1'b1;
        flag_nxt = 1'b1;
      end
    end

    if (clr_hold) begin
      hold_nxt = '0;
      flag_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long;

  btn_conditioner #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  // Reference model: raw delayed two edges, then a run-length debouncer on the
  // synchronized value and a "cycles since press" timer for the long event.
  bit m_s1, m_s2, m_level, m_long_done;
  int m_run, m_since;
  bit e_press, e_rel, e_long;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int press_cyc, rel_cyc, long_cyc;
  int press_cnt, rel_cnt, long_cnt;
  int t0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
    m_since = 0; m_long_done = 1;
    e_press = 0; e_rel = 0; e_long = 0;
  endtask

  task automatic clr_counts();
    press_cnt = 0; rel_cnt = 0; long_cnt = 0;
    press_cyc = -1000; rel_cyc = -1000; long_cyc = -1000;
  endtask

  // Drive one raw value across one clock edge, advance the model, check outputs.
  task automatic step(input logic r);
    bit sync_now, prior;
    btn_raw = r;
    @(posedge clk);
    cyc++;
    sync_now = m_s2;
    prior    = m_level;
    m_s2 = m_s1;
    m_s1 = r;
    e_press = 0; e_rel = 0; e_long = 0;
    if (prior) begin
      m_since++;
      if (m_since == LONG && !m_long_done) begin
        e_long = 1;
        m_long_done = 1;
      end
    end
    if (sync_now != m_level) m_run++;
    else m_run = 0;
    if (m_run == DEB) begin
      m_run = 0;
      m_level = !m_level;
      if (m_level) begin
        e_press = 1;
        m_since = 0;
        m_long_done = 0;
      end else begin
        e_rel = 1;
      end
    end
    #1;
    chk("level", btn_level, m_level);
    chk("press", btn_press, e_press);
    chk("release", btn_release, e_rel);
    chk("long", btn_long, e_long);
    if (btn_press)   begin press_cnt++; press_cyc = cyc; end
    if (btn_release) begin rel_cnt++;   rel_cyc   = cyc; end
    if (btn_long)    begin long_cnt++;  long_cyc  = cyc; end
  endtask

  task automatic run(input logic r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Hold raw high until a press is seen (bounded), return the latency.
  task automatic press_until(output int lat);
    int start;
    start = cyc;
    for (int i = 0; i < 3 * DEB + 4; i++) begin
      step(1'b1);
      if (btn_press) break;
    end
    lat = cyc - start;
  endtask

  task automatic release_until(output int lat);
    int start;
    start = cyc;
    for (int i = 0; i < 3 * DEB + 4; i++) begin
      step(1'b0);
      if (btn_release) break;
    end
    lat = cyc - start;
  endtask

  initial begin
    int lat, p;
    model_reset();
    clr_counts();

    // Reset state
    #12;
    chk("rst_level", btn_level, 1'b0);
    chk("rst_press", btn_press, 1'b0);
    chk("rst_release", btn_release, 1'b0);
    chk("rst_long", btn_long, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 3);

    // 1: clean press held 10 cycles, then released
    clr_counts();
    press_until(lat);
    chk_int("t1_press_lat", lat, DEB + 2);
    run(1, 10 - lat);
    release_until(lat);
    chk_int("t1_rel_lat", lat, DEB + 2);
    chk_int("t1_long_cnt", long_cnt, 0);
    chk_int("t1_press_cnt", press_cnt, 1);
    run(0, 4);

    // 2: bounce shorter than the debounce window
    clr_counts();
    run(1, 2); run(0, 2); run(1, 2); run(0, 10);
    chk_int("t2_events", press_cnt + rel_cnt + long_cnt, 0);

    // 3: hold 40 cycles, exactly one long 20 cycles after press
    clr_counts();
    press_until(lat);
    run(1, 40 - lat);
    chk_int("t3_long_cnt", long_cnt, 1);
    chk_int("t3_long_dly", long_cyc - press_cyc, LONG);
    run(0, 10);
    chk_int("t3_rel_cnt", rel_cnt, 1);

    // 4: short drop while held is rejected, long still on time
    clr_counts();
    press_until(lat);
    run(1, 3); run(0, 2); run(1, 25);
    chk_int("t4_rel_cnt", rel_cnt, 0);
    chk_int("t4_long_cnt", long_cnt, 1);
    chk_int("t4_long_dly", long_cyc - press_cyc, LONG);
    run(0, 10);

    // 5: reset mid-HELD with button still pressed
    clr_counts();
    press_until(lat);
    run(1, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_level", btn_level, 1'b0);
    chk("t5_rst_press", btn_press, 1'b0);
    #20;
    chk("t5_rst_hold_level", btn_level, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    press_until(lat);
    chk_int("t5_press_lat", lat, DEB + 2);
    run(1, 2);
    run(0, 10);

    // 6: release acceptance lands exactly on the long threshold
    clr_counts();
    press_until(lat);
    p = cyc;
    run(1, LONG - DEB - 2);
    run(0, DEB + 2);
    chk_int("t6_cycle", cyc - p, LONG);
    chk("t6_long", btn_long, 1'b1);
    chk("t6_release", btn_release, 1'b1);
    run(0, 6);

    // Random bursts against the model
    for (int b = 0; b < 60; b++) begin
      logic r;
      int len;
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) len = $urandom_range(15, 30);
      else len = $urandom_range(1, 8);
      run(r, len);
    end
    run(0, 12);
    chk("end_level", btn_level, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

- Turns a raw, bouncing, asynchronous push-button input into clean single-cycle events for the control FSMs (start/stop toggle, lap/reset logic).
- Event outputs:
  - `btn_press`: exactly one cycle per debounced press. This is the signal the start/stop FSM consumes.
  - `btn_long`: one cycle once per press, when the button is held long enough.
  - `btn_release`: one cycle per debounced release.
- Sits between the board button pin and the FSMs, one instance per button.

## Interface

- `DEB_CYCLES`, default 20000: consecutive stable cycles required to accept a press or a release. Must be ≥ 1.
- `LONG_CYCLES`, default 2000000: cycles after `btn_press` at which `btn_long` fires. Must be > `DEB_CYCLES`.
- `CNT_W`, default 24: counter width. Must satisfy 2^`CNT_W` > `LONG_CYCLES`.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_raw`  in  1  raw button pin, asynchronous to `clk`, active-high
- `btn_level`  out  1  debounced button level
- `btn_press`  out  1  one-cycle pulse on accepted press
- `btn_release`  out  1  one-cycle pulse on accepted release
- `btn_long`  out  1  one-cycle pulse, at most once per press

## Operation

**Input path**
- `btn_raw` passes through a two-flop synchronizer, giving `btn_sync`.
- The FSM and counters use only `btn_sync`.

**State machine:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE
  - `btn_level` = 0.
  - `btn_sync` = 1 → PRESS_WAIT, with `deb_cnt` cleared.
- PRESS_WAIT
  - `btn_sync` = 0 → IDLE. Bounce is rejected and no output is produced.
  - When `btn_sync` has been 1 for `DEB_CYCLES` consecutive cycles → HELD.
  - On this transition: `btn_press` = 1 for one cycle, `btn_level` becomes 1, `hold_cnt` cleared, long-reported flag cleared.
- HELD
  - `btn_sync` = 0 → RELEASE_WAIT, with `deb_cnt` cleared.
- RELEASE_WAIT
  - `btn_level` stays 1.
  - `btn_sync` = 1 → HELD. Release bounce is rejected; `hold_cnt` is not reset.
  - When `btn_sync` has been 0 for `DEB_CYCLES` consecutive cycles → IDLE.
  - On this transition: `btn_release` = 1 for one cycle, `btn_level` becomes 0.

**Hold counter**
- `hold_cnt` increments every cycle in HELD and RELEASE_WAIT.
- It saturates at `LONG_CYCLES` and never wraps.
- When `hold_cnt` reaches `LONG_CYCLES` and the long-reported flag is clear:
  - `btn_long` = 1 for one cycle;
  - the flag is set.

**Simultaneous events**
- If the long threshold is reached in the same cycle as the RELEASE_WAIT → IDLE transition, both `btn_long` and `btn_release` pulse in that cycle.
- `btn_press` can never coincide with `btn_release` or `btn_long`.

## Timing

- All outputs are registered. Reset value of every output is 0, state is IDLE, counters are 0.
- Press latency: with `btn_raw` rising before edge k and held stable, `btn_press` is high in the cycle after edge k + 1 + `DEB_CYCLES`. That is `DEB_CYCLES` + 2 cycles after first sampling.
- Release latency: symmetric, `DEB_CYCLES` + 2 cycles from `btn_raw` falling to the `btn_release` pulse.
- `btn_long` is high exactly `LONG_CYCLES` cycles after the `btn_press` cycle, provided no accepted release occurs before then.
- Pulse width: every pulse lasts exactly 1 cycle. Pulses never repeat while the level is unchanged.
- Glitches: a pulse on `btn_raw` shorter than `DEB_CYCLES` cycles, as seen at `btn_sync`, produces no output change.
- Reset mid-operation:
  - Asserting `rst_n` low clears all state and outputs immediately (asynchronously).
  - If the button is held through reset release, a fresh `btn_press` is produced `DEB_CYCLES` + 2 cycles after reset release.
  - Synchronizer flops reset to 0.

## Structure

- Shared definitions header: board default values for `DEB_CYCLES` and `LONG_CYCLES`, derived from the board clock frequency, so every button instance agrees.
- State encoding is local to the block.
- One sub-module: `sync_2ff`, a two-flop synchronizer with asynchronous active-low reset to 0. It is reused for every asynchronous pin.
- Counters:
  - `deb_cnt` is shared by PRESS_WAIT and RELEASE_WAIT and is cleared on every state change;
  - `hold_cnt` is separate.

## Test plan

Bench parameters: `DEB_CYCLES` = 4, `LONG_CYCLES` = 20, `CNT_W` = 8.

1. Clean press held 10 cycles, then released → `btn_press` one cycle, 6 cycles after the rise. `btn_level` high until `btn_release`, which pulses 6 cycles after the fall. No `btn_long`.
2. Bounce: `btn_raw` toggles 1,0,1,0 at 2-cycle intervals, then stays low → all outputs stay 0 throughout.
3. Hold 40 cycles → exactly one `btn_long`, 20 cycles after `btn_press`. No second pulse before release.
4. While held past `btn_press`, `btn_raw` drops for 2 cycles then returns → no `btn_release`. `btn_long` still fires 20 cycles after `btn_press`.
5. Assert `rst_n` low mid-HELD while the button stays pressed → outputs 0 immediately. After reset release, `btn_press` fires again 6 cycles later.
6. Release timed so `hold_cnt` hits 20 in the same cycle as the release acceptance → `btn_long` and `btn_release` both pulse in that cycle.
